// File: rtl/bga_fault_reporter.sv
// Reports newly failing BGA pin-pair indices as "HH\r\n" over an 8N1 UART.
// Optional BGA_REPORT_PASS_EN: send "OK\r\n" after a clean sweep.
module bga_fault_reporter #(
    parameter int N_PAIR     = 86,
    parameter int IDX_W      = 7,
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chk_valid,
    input  logic [IDX_W-1:0] chk_index,
    input  logic             chk_fail,
    input  logic             chk_wrap,
    output logic             uart_tx,
    output logic             tx_busy,
    output logic             fail_seen,
    output logic             overflow,
    output logic [IDX_W:0]   fail_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [N_PAIR-1:0] reported;
    logic [IDX_W-1:0]  mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              in_range;
    logic              enq_try;
    logic              push;
    logic              pop;
    logic              pass_go;

    tx_state_t         state_q, state_n;
    logic [15:0]       div_q, div_n;
    logic [2:0]        bit_q, bit_n;
    logic [1:0]        sel_q, sel_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic              pass_q, pass_n;
    logic              div_done;
    logic [7:0]        idx8;
    logic [3:0]        nib;
    logic [7:0]        cur_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                   && (wr_ptr[AW] != rd_ptr[AW]);
    assign in_range = ({1'b0, chk_index} < (IDX_W+1)'(N_PAIR));
    assign enq_try  = chk_valid & chk_fail & in_range & !reported[chk_index];
    // Full is judged before this cycle's pop, so a pop never frees a slot early
    assign push     = enq_try & !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            reported   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fail_seen  <= 1'b0;
            overflow   <= 1'b0;
            fail_count <= '0;
        end else begin
            if (push) begin
                wr_ptr              <= wr_ptr + 1'b1;
                reported[chk_index] <= 1'b1;
                fail_seen           <= 1'b1;
                if (fail_count != (IDX_W+1)'(N_PAIR))
                    fail_count <= fail_count + 1'b1;
            end
            if (enq_try && full)
                overflow <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= chk_index;
    end

`ifdef BGA_REPORT_PASS_EN
    logic dirty_q;

    always_ff @(posedge clk) begin
        if (reset)
            dirty_q <= 1'b0;
        else if (chk_wrap)
            dirty_q <= 1'b0;
        else if (enq_try)
            dirty_q <= 1'b1;
    end

    assign pass_go = chk_wrap & !dirty_q & !enq_try & empty
                   & (state_q == IDLE);
`else
    logic unused_wrap;
    assign unused_wrap = chk_wrap;
    assign pass_go     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sel_q   <= '0;
            idx_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            div_q   <= div_n;
            bit_q   <= bit_n;
            sel_q   <= sel_n;
            idx_q   <= idx_n;
            pass_q  <= pass_n;
        end
    end

    assign div_done = (div_q == 16'(CLK_DIV - 1));

    always_comb begin
        state_n = state_q;
        div_n   = div_q;
        bit_n   = bit_q;
        sel_n   = sel_q;
        idx_n   = idx_q;
        pass_n  = pass_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    idx_n   = mem[rd_ptr[AW-1:0]];
                    pass_n  = 1'b0;
                    sel_n   = '0;
                    div_n   = '0;
                    state_n = START;
                end else if (pass_go) begin
                    pass_n  = 1'b1;
                    sel_n   = '0;
                    div_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (div_done) begin
                    div_n   = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    div_n = div_q + 16'd1;
                end
            end
            DATA: begin
                if (div_done) begin
                    div_n = '0;
                    if (bit_q == 3'd7)
                        state_n = STOP;
                    else
                        bit_n = bit_q + 3'd1;
                end else begin
                    div_n = div_q + 16'd1;
                end
            end
            STOP: begin
                if (div_done) begin
                    div_n = '0;
                    if (sel_q != 2'd3) begin
                        sel_n   = sel_q + 2'd1;
                        state_n = START;
                    end else if (!empty) begin
                        // Chain straight into the next report, no idle gap
                        pop     = 1'b1;
                        idx_n   = mem[rd_ptr[AW-1:0]];
                        pass_n  = 1'b0;
                        sel_n   = '0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    div_n = div_q + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign idx8 = 8'(idx_q);
    assign nib  = sel_q[0] ? idx8[3:0] : idx8[7:4];

    always_comb begin
        cur_byte = 8'h0A;
        unique case (sel_q)
            2'd0:    cur_byte = pass_q ? 8'h4F : hex_ascii(nib);
            2'd1:    cur_byte = pass_q ? 8'h4B : hex_ascii(nib);
            2'd2:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    assign uart_tx = (state_q == START) ? 1'b0
                   : (state_q == DATA)  ? cur_byte[bit_q]
                   : 1'b1;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_bga_fault_reporter.sv
// Directed bench for bga_fault_reporter with CLK_DIV=4 and a UART receiver.
// Pass-report checks run only when BGA_REPORT_PASS_EN is defined.
module tb_bga_fault_reporter;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       chk_valid;
    logic [6:0] chk_index;
    logic       chk_fail;
    logic       chk_wrap;
    logic       uart_tx;
    logic       tx_busy;
    logic       fail_seen;
    logic       overflow;
    logic [7:0] fail_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] rx_data;
    logic       rx_busy = 1'b0;
    int         rx_cnt = 0;
    int         frame_err = 0;
    int         busy_cycles = 0;

    bga_fault_reporter #(
        .N_PAIR(86), .IDX_W(7), .CLK_DIV(DIV), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset),
        .chk_valid(chk_valid), .chk_index(chk_index),
        .chk_fail(chk_fail), .chk_wrap(chk_wrap),
        .uart_tx(uart_tx), .tx_busy(tx_busy),
        .fail_seen(fail_seen), .overflow(overflow),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    // Receiver: start seen at count 0, bit i sampled mid-bit, stop at 38
    always @(negedge clk) begin
        if (reset) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (!uart_tx) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 1;
            end
        end else begin
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % DIV) == 2)
                rx_data[(rx_cnt - 6) / DIV] <= uart_tx;
            if (rx_cnt == 38) begin
                if (uart_tx) rx_q.push_back(rx_data);
                else frame_err <= frame_err + 1;
            end
            if (rx_cnt == 39) rx_busy <= 1'b0;
            rx_cnt <= rx_cnt + 1;
        end
    end

    always @(negedge clk)
        if (tx_busy) busy_cycles <= busy_cycles + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [31:0] exp_word(input logic [7:0] idx);
        return {hexc(idx[7:4]), hexc(idx[3:0]), 8'h0D, 8'h0A};
    endfunction

    function automatic logic [31:0] word_at(input int k);
        if (rx_q.size() < 4 * k + 4) return 32'hFFFF_FFFF;
        return {rx_q[4*k], rx_q[4*k+1], rx_q[4*k+2], rx_q[4*k+3]};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        rx_q.delete();
    endtask

    task automatic fail_pulse(input int idx);
        chk_valid = 1'b1;
        chk_fail  = 1'b1;
        chk_index = 7'(idx);
        @(negedge clk);
        chk_valid = 1'b0;
        chk_fail  = 1'b0;
    endtask

    task automatic wrap_pulse();
        chk_wrap = 1'b1;
        @(negedge clk);
        chk_wrap = 1'b0;
    endtask

    initial begin
        int bc0;
        reset     = 1'b1;
        chk_valid = 1'b0;
        chk_fail  = 1'b0;
        chk_index = '0;
        chk_wrap  = 1'b0;
        step(3);
        check("rst_tx", 32'(uart_tx), 1);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_seen", 32'(fail_seen), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_cnt", 32'(fail_count), 0);
        reset = 1'b0;
        step(2);

        // Single failure on pair 5
        bc0 = busy_cycles;
        fail_pulse(5);
        step(200);
        check("one_len", rx_q.size(), 4);
        check("one_word", word_at(0), 32'h3035_0D0A);
        check("one_cnt", 32'(fail_count), 1);
        check("one_seen", 32'(fail_seen), 1);
        check("one_frame", busy_cycles - bc0, 40 * DIV);

        // Same pair over three sweeps, then an out-of-range index
        for (int s = 0; s < 3; s++) begin
            fail_pulse(5);
            step(3);
            wrap_pulse();
        end
        step(200);
        check("rep_len", rx_q.size(), 4);
        check("rep_cnt", 32'(fail_count), 1);
        fail_pulse(86);
        step(60);
        check("oor_len", rx_q.size(), 4);
        check("oor_cnt", 32'(fail_count), 1);
        check("oor_busy", 32'(tx_busy), 0);
        check("oor_ovf", 32'(overflow), 0);

        // Ten fails on consecutive cycles into an 8-deep FIFO
        do_reset();
        chk_valid = 1'b1;
        chk_fail  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk_index = 7'(i);
            @(negedge clk);
        end
        chk_valid = 1'b0;
        chk_fail  = 1'b0;
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_cnt", 32'(fail_count), 9);
        step(200);
        chk_valid = 1'b1;
        chk_fail  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk_index = 7'(i);
            @(negedge clk);
        end
        chk_valid = 1'b0;
        chk_fail  = 1'b0;
        step(1800);
        check("ovf_len", rx_q.size(), 40);
        for (int k = 0; k < 10; k++)
            check($sformatf("ovf_word%0d", k), word_at(k), exp_word(8'(k)));
        check("ovf_cnt2", 32'(fail_count), 10);
        check("ovf_busy", 32'(tx_busy), 0);

        // Reset while the second byte's data bits are on the line
        do_reset();
        fail_pulse(8'h1F);
        step(55);
        check("mid_busy0", 32'(tx_busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_tx", 32'(uart_tx), 1);
        check("mid_busy", 32'(tx_busy), 0);
        check("mid_cnt", 32'(fail_count), 0);
        reset = 1'b0;
        step(200);
        check("mid_len", rx_q.size(), 1);
        check("mid_byte", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF, 32'h31);
        check("mid_idle", 32'(tx_busy), 0);

`ifdef BGA_REPORT_PASS_EN
        do_reset();
        step(3);
        wrap_pulse();
        step(200);
        check("pass_len", rx_q.size(), 4);
        check("pass_word", word_at(0), 32'h4F4B_0D0A);
        fail_pulse(3);
        step(3);
        wrap_pulse();
        step(200);
        check("pfail_len", rx_q.size(), 8);
        check("pfail_word", word_at(1), 32'h3033_0D0A);
`endif

        check("frame_err", frame_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bga_fault_reporter.md
Name: bga_fault_reporter

Overview:
- Consumes per-step results from the walking-one pin-pair scanner and reports each newly failing pair index over a UART transmit line, so the operator can see which solder joint failed.
- Sits between the scan/compare logic and a spare FPGA pin wired to a USB-UART bridge.
- Reports each pair once: a per-pair bitmap suppresses repeat reports across sweeps. A small FIFO decouples the fast scan rate from the slow serial rate.

Parameters:
- N_PAIR, 86, number of pin pairs under test.
- IDX_W, 7, width of the pair index; requires 2^IDX_W >= N_PAIR and IDX_W <= 8.
- CLK_DIV, 434, clk cycles per UART bit, range 2..65535.
- FIFO_DEPTH, 8, pending-report FIFO entries; power of 2.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- chk_valid  in  1  one-cycle strobe per scan step.
- chk_index  in  IDX_W  pair driven in this step, 0..N_PAIR-1.
- chk_fail  in  1  observed inputs differed from expected this step; qualified by chk_valid.
- chk_wrap  in  1  one-cycle pulse at the end of a full sweep.
- uart_tx  out  1  8N1 serial output; idle high.
- tx_busy  out  1  high while a frame is being shifted.
- fail_seen  out  1  sticky; at least one failure has been enqueued.
- overflow  out  1  sticky; a failure was dropped because the FIFO was full.
- fail_count  out  IDX_W+1  number of distinct pairs enqueued, saturating at N_PAIR.

Behaviour:
- Reset: every state is cleared in the same cycle, including mid-frame; no partial frame completes.
  - uart_tx=1, tx_busy=0, fail_seen=0, overflow=0, fail_count=0.
  - Bitmap and FIFO cleared; TX FSM returns to IDLE.
- Enqueue rule: on chk_valid & chk_fail & chk_index<N_PAIR & !reported[chk_index]:
  - If FIFO not full: push index, set reported[chk_index], set fail_seen, increment fail_count.
  - If FIFO full: set overflow; bitmap bit stays clear so the pair retries on the next sweep.
  - An index >= N_PAIR is ignored entirely.
- The enqueue path decides in one cycle. The FIFO entry is visible to the TX FSM on the next cycle.
- FIFO push and pop may occur in the same cycle. When the FIFO is full, a simultaneous pop does not free space for that cycle's push; the push is dropped and overflow is set.
- Report format: 4 bytes per entry.
  - ASCII uppercase hex of the zero-extended 8-bit index, high nibble first.
  - Then 0x0D, then 0x0A.
  - Example: index 0x2A sends '2' '4'... no: sends 0x32 0x41 0x0D 0x0A.
- UART framing: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly CLK_DIV cycles. A 4-byte report takes 40*CLK_DIV cycles.
- TX FSM states:
  - IDLE: if FIFO not empty, pop an entry, byte_sel=0, go to START.
  - START: drive 0 for CLK_DIV cycles, then go to DATA.
  - DATA: drive 8 bits, then go to STOP.
  - STOP: drive 1 for CLK_DIV cycles. If byte_sel<3, increment byte_sel and go to START; else go to IDLE.
  - Back-to-back reports have no extra idle bit between them.
- tx_busy is high in START, DATA and STOP.
- chk_wrap has no effect unless the optional feature is compiled in.

Optional Feature:
- Macro: BGA_REPORT_PASS_EN.
- Defined: on chk_wrap, if no failure was enqueued or dropped since the previous chk_wrap (or since reset), and the FIFO is empty and the FSM is IDLE, send "OK" 0x0D 0x0A. This is a 4-byte frame using the same FSM, marked by an internal pass flag. If the conditions are not met at chk_wrap, the pass report for that sweep is skipped; it is never queued.
- Undefined: chk_wrap is ignored and no pass frames are sent.

Test Plan:
- Reset then single fail: chk_index=5, chk_fail=1 -> uart_tx decodes 0x30 0x35 0x0D 0x0A; fail_count=1; frame lasts 40*CLK_DIV cycles (CLK_DIV=4 in the bench).
- Repeat suppression: pair 5 fails in 3 consecutive sweeps -> exactly one report; fail_count=1.
- Overflow: 10 distinct fails (indices 0..9) in quick succession with FIFO_DEPTH=8 while TX is busy:
  - The first dequeued entry frees a slot, so 9 entries are accepted in total and one is dropped.
  - overflow=1.
  - The dropped index re-fails next sweep and is reported; the final fail_count=10.
- Out-of-range index: chk_index=86 with chk_fail=1 -> no report; counters unchanged.
- Reset during the DATA bit of the second byte -> uart_tx=1 on the next cycle; FIFO empty; no further bytes sent.
- With BGA_REPORT_PASS_EN: a clean sweep then chk_wrap -> 0x4F 0x4B 0x0D 0x0A. A sweep with one fail then chk_wrap -> only the fail report.
